dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WORD, default 64, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, number of WORD-wide storage entries.
REQ-003 SHALL have parameter LATENCY, default 2, clock cycles from acceptance to response (legal range 1..15).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, datapath presents a load or store request.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request this cycle.
REQ-008 SHALL have port req_write, input, 1, 1 = store (STUR), 0 = load (LDUR).
REQ-009 SHALL have port req_addr, input, WORD, byte address (ALU result).
REQ-010 SHALL have port req_wdata, input, WORD, store data (read_data2).
REQ-011 SHALL have port rsp_valid, output, 1, response available.
REQ-012 SHALL have port rsp_ready, input, 1, datapath consumes response.
REQ-013 SHALL have port rsp_rdata, output, WORD, load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where state = IDLE and req_valid = 1, capturing write, addr and wdata, loading countdown with LATENCY-1, then entering BUSY.
REQ-017 SHALL, when LATENCY = 1, go from acceptance directly to RESP in the next cycle, skipping BUSY.
REQ-018 SHALL decrement the countdown each cycle in BUSY and enter RESP on the edge where it reaches 0, so rsp_valid first asserts exactly LATENCY cycles after the accept edge.
REQ-019 SHALL compute index = addr[log2(DEPTH)+2:3]; a request is in error if addr[2:0] != 0 or addr >= DEPTH*8.
REQ-020 SHALL perform a non-error store on the BUSY->RESP (or accept->RESP) transition edge, writing the full WORD; an error store SHALL NOT modify memory.
REQ-021 SHALL register rsp_rdata on that same edge: the memory word for a non-error load, 0 otherwise; rsp_err is registered on the same edge.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge with rsp_valid = 0.
REQ-023 SHALL ignore req_valid while in BUSY or RESP; captured request fields SHALL NOT change.
REQ-024 SHALL make a load that follows a store to the same address return the stored value (no stale read).
REQ-025 SHALL not accept a new request in the same cycle a response is consumed; minimum spacing between accepts is LATENCY+1 cycles.

Reset
REQ-026 SHALL, while reset = 0, force state IDLE, countdown 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, and all DEPTH entries to 0, asynchronously.
REQ-027 SHALL, on reset assertion mid-transaction (BUSY or RESP), abandon the transaction with no memory write and no response.
REQ-028 SHALL, on reset release, accept a request no earlier than the first rising edge with reset = 1.

Verification
REQ-029 SHALL verify: reset, then load addr 0x10 -> rsp_valid exactly 2 cycles after accept, rsp_rdata 0, rsp_err 0.
REQ-030 SHALL verify: store 0x1234 to addr 0x18, then load 0x18 -> rsp_rdata 0x1234, rsp_err 0.
REQ-031 SHALL verify: load addr 0x13 (misaligned) and addr 0x400 (DEPTH*8) -> rsp_err 1, rsp_rdata 0; a store to 0x400 leaves entry 0 unchanged.
REQ-032 SHALL verify: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable, req_ready stays 0, and req_valid pulses are ignored.
REQ-033 SHALL verify: assert reset during BUSY of a store of 0xFF to 0x8 -> rsp_valid never rises, and a load of 0x8 after release returns 0.
REQ-034 SHALL verify: store to the last entry (0x3F8) then load it back -> value returned with rsp_err 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake.
// One outstanding transaction; the response arrives a fixed LATENCY after acceptance.
module dmem_responder #(
    parameter int WORD    = 64,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [WORD-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int              IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD-1:0] LIMIT     = WORD'(DEPTH * 8);
    localparam logic [3:0]      CNT_INIT  = 4'(LATENCY - 1);
    localparam logic            SKIP_BUSY = (LATENCY == 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic            cap_write;
    logic [WORD-1:0] cap_addr;
    logic [WORD-1:0] cap_wdata;
    logic [WORD-1:0] mem [DEPTH];

    logic            op_write;
    logic [WORD-1:0] op_addr;
    logic [WORD-1:0] op_wdata;
    logic            op_err;
    logic [IW-1:0]   op_idx;
    logic            finish;
    logic [WORD-1:0] rd_word;

    // With LATENCY = 1 the request completes on its own accept edge, so the
    // operands come straight from the request port instead of the capture regs.
    always_comb begin
        op_write = (state == IDLE) ? req_write : cap_write;
        op_addr  = (state == IDLE) ? req_addr  : cap_addr;
        op_wdata = (state == IDLE) ? req_wdata : cap_wdata;
        op_err   = (op_addr[2:0] != 3'd0) || (op_addr >= LIMIT);
        op_idx   = op_addr[IW+2:3];
        finish   = (state == IDLE && req_valid && SKIP_BUSY) ||
                   (state == BUSY && cnt <= 4'd1);
        rd_word  = (!op_write && !op_err) ? mem[op_idx] : '0;
    end

    assign req_ready = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cnt       <= CNT_INIT;
                        state     <= SKIP_BUSY ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt <= 4'd1) begin
                        cnt   <= '0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (finish) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rd_word;
                rsp_err   <= op_err;
            end
        end
    end

    // NOTE: the storage is cleared by reset, so it is built from resettable
    // flops rather than a RAM macro; a reset-less array would come up as X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (finish && op_write && !op_err) begin
            mem[op_idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (WORD 64, DEPTH 128, LATENCY 2).
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request/response with immediate consume; response expected one edge
    // after the accept edge, i.e. in the second cycle counting the accept cycle.
    task automatic txn(input string tag, input logic wr, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] exp_rdata,
                       input logic exp_err);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        check({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check({tag, ".busy_ready"}, 64'(req_ready), 64'd0);
        check({tag, ".busy_valid"}, 64'(rsp_valid), 64'd0);
        tick();
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state, with a request presented that must not be taken.
        req_valid = 1'b1;
        tick();
        tick();
        check("rst.req_ready", 64'(req_ready), 64'd1);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_rdata", rsp_rdata, 64'd0);
        check("rst.rsp_err", 64'(rsp_err), 64'd0);
        req_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Basic load and store/load round trip.
        txn("ld10", 1'b0, 64'h10, 64'h0, 64'h0, 1'b0);
        txn("st18", 1'b1, 64'h18, 64'h1234, 64'h0, 1'b0);
        txn("ld18", 1'b0, 64'h18, 64'h0, 64'h1234, 1'b0);

        // Error cases: misaligned, first out-of-range address, and an
        // out-of-range store that aliases entry 0 in its index bits.
        txn("ld13", 1'b0, 64'h13, 64'h0, 64'h0, 1'b1);
        txn("ld400", 1'b0, 64'h400, 64'h0, 64'h0, 1'b1);
        txn("st400", 1'b1, 64'h400, 64'hDEAD_BEEF, 64'h0, 1'b1);
        txn("ld0", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0);
        txn("st1b", 1'b1, 64'h1B, 64'h7777, 64'h0, 1'b1);
        txn("ld18b", 1'b0, 64'h18, 64'h0, 64'h1234, 1'b0);

        // Stall in RESP with ignored request pulses; a store presented
        // during BUSY must not replace the captured load.
        txn("st20", 1'b1, 64'h20, 64'hABCD, 64'h0, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h20;
        tick();
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'h9999;
        check("stall.busy_ready", 64'(req_ready), 64'd0);
        tick();
        check("stall.rsp_valid0", 64'(rsp_valid), 64'd1);
        check("stall.rsp_rdata0", rsp_rdata, 64'hABCD);
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0];
            tick();
            check($sformatf("stall.valid%0d", i), 64'(rsp_valid), 64'd1);
            check($sformatf("stall.rdata%0d", i), rsp_rdata, 64'hABCD);
            check($sformatf("stall.err%0d", i), 64'(rsp_err), 64'd0);
            check($sformatf("stall.ready%0d", i), 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("stall.done_valid", 64'(rsp_valid), 64'd0);
        txn("ld20", 1'b0, 64'h20, 64'h0, 64'hABCD, 1'b0);

        // Reset asserted while a store is in BUSY.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h8;
        req_wdata = 64'hFF;
        tick();
        req_valid = 1'b0;
        check("rbusy.busy_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("rbusy.async_ready", 64'(req_ready), 64'd1);
        check("rbusy.async_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rbusy.valid%0d", i), 64'(rsp_valid), 64'd0);
        end
        reset = 1'b1;
        tick();
        check("rbusy.post_valid", 64'(rsp_valid), 64'd0);
        txn("ld8", 1'b0, 64'h8, 64'h0, 64'h0, 1'b0);
        txn("ld18c", 1'b0, 64'h18, 64'h0, 64'h0, 1'b0);

        // Last entry, then a request held across the consume edge is taken
        // only on the following edge.
        txn("st3f8", 1'b1, 64'h3F8, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h3F8;
        tick();
        req_valid = 1'b0;
        tick();
        check("ld3f8.rsp_valid", 64'(rsp_valid), 64'd1);
        check("ld3f8.rsp_rdata", rsp_rdata, 64'hCAFE_F00D_1234_5678);
        check("ld3f8.rsp_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h18;
        tick();
        rsp_ready = 1'b0;
        check("space.consume_valid", 64'(rsp_valid), 64'd0);
        check("space.consume_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("space.accept_ready", 64'(req_ready), 64'd0);
        tick();
        check("space.rsp_valid", 64'(rsp_valid), 64'd1);
        check("space.rsp_rdata", rsp_rdata, 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("space.done_ready", 64'(req_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
